// File: rtl/block_drop_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : block_drop_pkg                                             |
// | Purpose : Shared state codes and board geometry for the falling-     |
// |           block game sequencer.                                      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package block_drop_pkg;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_MOVING  = 3'd1,
    S_PAUSE   = 3'd2,
    S_FALLING = 3'd3,
    S_LAND    = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam int         NUM_COLS = 4;
  localparam int         NUM_ROWS = 3;
  localparam logic [1:0] MAX_H    = 2'd3;

endpackage : block_drop_pkg
`default_nettype wire

// File: rtl/tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tick_counter                                               |
// | Purpose : Counts enabled cycles; synchronous clear wins over enable. |
// | Ports   : clk, rst (async, active-high), clr, en -> count[CNT_W-1:0] |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tick_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : tick_counter
`default_nettype wire

// File: rtl/block_drop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : block_drop_ctrl                                            |
// | Purpose : Falling-block game sequencer. Owns the INIT/MOVING/PAUSE/  |
// |           FALLING/LAND/OVER flow, the active block position and the  |
// |           per-column stack heights. Timing comes from a one-cycle    |
// |           tick enable.                                               |
// | Ports   : clk, rst (async, active-high), tick,                       |
// |           btn_left/right/up/down (one-cycle pulses)                  |
// |           -> state[2:0], col[1:0], row[1:0], heights[7:0]            |
// |              ({h3,h2,h1,h0}), landed (pulse), game_over              |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module block_drop_ctrl
  import block_drop_pkg::*;
#(
  parameter int INIT_TICKS = 6,
  parameter int FALL_TICKS = 1,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] state,
  output logic [1:0] col,
  output logic [1:0] row,
  output logic [7:0] heights,
  output logic       landed,
  output logic       game_over
);

  localparam logic [1:0]       LAST_COL  = 2'(NUM_COLS - 1);
  localparam logic [1:0]       LAST_ROW  = 2'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TICKS - 1);
  localparam logic [CNT_W-1:0] FALL_LAST = CNT_W'(FALL_TICKS - 1);

  state_t     state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [7:0] heights_q, heights_d;
  logic       landed_q, landed_d;
  logic       game_over_q, game_over_d;

  logic [CNT_W-1:0] count;
  logic             cnt_clr;
  logic             cnt_en;
  logic [1:0]       h_col;
  logic [1:0]       land_row;
  logic             init_done;
  logic             fall_step;
  logic             all_full;

  // Transitions fire on the tick that completes the interval, so the new
  // state is visible the cycle after that tick rather than one cycle later.
  assign h_col     = heights_q[{col_q, 1'b0} +: 2];
  assign land_row  = LAST_ROW - h_col;
  assign init_done = tick && (count == INIT_LAST);
  assign fall_step = (state_q == S_FALLING) && tick && (count == FALL_LAST);
  assign all_full  = (heights_q == {NUM_COLS{MAX_H}});

  // Clearing on any state change also drops a tick that coincides with the
  // change; each fall step restarts the interval.
  assign cnt_clr = (state_d != state_q) || fall_step;
  assign cnt_en  = tick && (state_q != S_PAUSE);

  tick_counter #(
    .CNT_W (CNT_W)
  ) u_tick_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (count)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    heights_d = heights_q;
    landed_d  = 1'b0;

    case (state_q)
      S_INIT: begin
        if (init_done) state_d = S_MOVING;
      end

      S_MOVING: begin
        if (btn_up) begin
          state_d = S_PAUSE;
        end else if (btn_down && (h_col != MAX_H)) begin
          state_d = S_FALLING;
        end else if (btn_left && !btn_right) begin
          if (col_q != 2'd0) col_d = col_q - 2'd1;
        end else if (btn_right && !btn_left) begin
          if (col_q != LAST_COL) col_d = col_q + 2'd1;
        end
      end

      S_PAUSE: begin
        if (btn_up) state_d = S_MOVING;
      end

      S_FALLING: begin
        if (fall_step) begin
          if (row_q < land_row) begin
            row_d = row_q + 2'd1;
          end else begin
            // Height and landed pulse are committed on entry to LAND so
            // both are visible during the single LAND cycle.
            state_d                         = S_LAND;
            heights_d[{col_q, 1'b0} +: 2]   = h_col + 2'd1;
            landed_d                        = 1'b1;
          end
        end
      end

      S_LAND: begin
        col_d   = 2'd0;
        row_d   = 2'd0;
        state_d = all_full ? S_OVER : S_INIT;
      end

      S_OVER: begin
        state_d = S_OVER;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase

    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      heights_q   <= 8'd0;
      landed_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      heights_q   <= heights_d;
      landed_q    <= landed_d;
      game_over_q <= game_over_d;
    end
  end

  assign state     = state_q;
  assign col       = col_q;
  assign row       = row_q;
  assign heights   = heights_q;
  assign landed    = landed_q;
  assign game_over = game_over_q;

endmodule : block_drop_ctrl
`default_nettype wire

// File: tb/tb_block_drop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_block_drop_ctrl                                         |
// | Purpose : Scoreboard bench for block_drop_ctrl. Scenario builders    |
// |           push stimulus and expected outputs; each test task drains  |
// |           the queues one cycle at a time and compares.               |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_block_drop_ctrl;

  localparam int ST_INIT = 0, ST_MOV = 1, ST_PAUSE = 2;
  localparam int ST_FALL = 3, ST_LAND = 4, ST_OVER = 5;

  // Stimulus word: {async_rst, tick, left, right, up, down}
  localparam logic [5:0] SN = 6'b000000;
  localparam logic [5:0] SD = 6'b000001;
  localparam logic [5:0] SU = 6'b000010;
  localparam logic [5:0] SR = 6'b000100;
  localparam logic [5:0] SL = 6'b001000;
  localparam logic [5:0] ST = 6'b010000;
  localparam logic [5:0] SX = 6'b100000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [2:0] state;
  logic [1:0] col, row;
  logic [7:0] heights;
  logic       landed, game_over;
  logic [16:0] obs;

  int checks = 0;
  int failures = 0;

  logic [5:0]  stim_q[$];
  logic [16:0] exp_q[$];
  logic [7:0]  e_h;

  always #5 clk = ~clk;

  assign obs = {state, col, row, heights, landed, game_over};

  block_drop_ctrl #(
    .INIT_TICKS (6),
    .FALL_TICKS (1),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .state     (state),
    .col       (col),
    .row       (row),
    .heights   (heights),
    .landed    (landed),
    .game_over (game_over)
  );

  function automatic logic [16:0] pk(input int st, input int c, input int r,
                                     input logic [7:0] h, input logic l, input logic g);
    return {3'(st), 2'(c), 2'(r), h, l, g};
  endfunction

  function automatic void add(input logic [5:0] s, input logic [16:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endfunction

  function automatic void build_reset();
    e_h = 8'd0;
    add(SX, pk(ST_INIT, 0, 0, 8'd0, 1'b0, 1'b0));
  endfunction

  // INIT with buttons ignored, then six ticks to MOVING.
  function automatic void build_init();
    add(SR | SD | SU, pk(ST_INIT, 0, 0, e_h, 1'b0, 1'b0));
    for (int i = 1; i <= 6; i++)
      add(ST, pk((i == 6) ? ST_MOV : ST_INIT, 0, 0, e_h, 1'b0, 1'b0));
  endfunction

  // From MOVING at column 0: walk to column c, drop, land, and return to
  // MOVING (or finish in OVER when the board fills).
  function automatic void build_drop(input int c);
    int lr;
    for (int k = 0; k < c; k++) add(SR, pk(ST_MOV, k + 1, 0, e_h, 1'b0, 1'b0));
    add(SD, pk(ST_FALL, c, 0, e_h, 1'b0, 1'b0));
    add(SL, pk(ST_FALL, c, 0, e_h, 1'b0, 1'b0));
    lr = 2 - int'(e_h[2*c +: 2]);
    for (int r = 1; r <= lr; r++) add(ST, pk(ST_FALL, c, r, e_h, 1'b0, 1'b0));
    e_h[2*c +: 2] = e_h[2*c +: 2] + 2'd1;
    add(ST, pk(ST_LAND, c, lr, e_h, 1'b1, 1'b0));
    if (e_h == 8'hFF) begin
      add(ST, pk(ST_OVER, 0, 0, e_h, 1'b0, 1'b1));
    end else begin
      // Tick during the LAND cycle must not count toward INIT.
      add(ST, pk(ST_INIT, 0, 0, e_h, 1'b0, 1'b0));
      build_init();
    end
  endfunction

  task automatic drive(input logic [5:0] s);
    @(negedge clk);
    rst = 1'b0;
    if (s[5]) begin
      #2 rst = 1'b1;
      #1;
    end else begin
      tick = s[4]; btn_left = s[3]; btn_right = s[2]; btn_up = s[1]; btn_down = s[0];
      @(posedge clk);
      #1;
      tick = 1'b0; btn_left = 1'b0; btn_right = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [16:0] e;
    int n = 0;
    rst = 1'b1;
    #3;
    build_reset();
    add(SN, pk(ST_INIT, 0, 0, 8'd0, 1'b0, 1'b0));
    add(SL | SR | SD, pk(ST_INIT, 0, 0, 8'd0, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset step %0d: got st=%0d col=%0d row=%0d h=%b ld=%b go=%b, want st=%0d col=%0d row=%0d h=%b ld=%b go=%b",
                 n, obs[16:14], obs[13:12], obs[11:10], obs[9:2], obs[1], obs[0],
                 e[16:14], e[13:12], e[11:10], e[9:2], e[1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_init();
    logic [16:0] e;
    int n = 0;
    build_init();
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL init step %0d: got st=%0d col=%0d row=%0d h=%b ld=%b go=%b, want st=%0d col=%0d row=%0d h=%b ld=%b go=%b",
                 n, obs[16:14], obs[13:12], obs[11:10], obs[9:2], obs[1], obs[0],
                 e[16:14], e[13:12], e[11:10], e[9:2], e[1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_moving();
    logic [16:0] e;
    int n = 0;
    for (int i = 1; i <= 5; i++) add(SR, pk(ST_MOV, (i < 3) ? i : 3, 0, e_h, 1'b0, 1'b0));
    add(SL | SR, pk(ST_MOV, 3, 0, e_h, 1'b0, 1'b0));
    add(ST,      pk(ST_MOV, 3, 0, e_h, 1'b0, 1'b0));
    for (int i = 1; i <= 4; i++) add(SL, pk(ST_MOV, (i < 3) ? 3 - i : 0, 0, e_h, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL moving step %0d: got st=%0d col=%0d row=%0d h=%b ld=%b go=%b, want st=%0d col=%0d row=%0d h=%b ld=%b go=%b",
                 n, obs[16:14], obs[13:12], obs[11:10], obs[9:2], obs[1], obs[0],
                 e[16:14], e[13:12], e[11:10], e[9:2], e[1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_drop();
    logic [16:0] e;
    int n = 0;
    build_drop(1);
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL drop step %0d: got st=%0d col=%0d row=%0d h=%b ld=%b go=%b, want st=%0d col=%0d row=%0d h=%b ld=%b go=%b",
                 n, obs[16:14], obs[13:12], obs[11:10], obs[9:2], obs[1], obs[0],
                 e[16:14], e[13:12], e[11:10], e[9:2], e[1], e[0]);
      end
      n++;
    end
    checks++;
    if (heights !== 8'b00_00_01_00) begin
      failures++;
      $display("FAIL drop_heights: got %b want %b", heights, 8'b00_00_01_00);
    end
  endtask

  task automatic test_full_column();
    logic [16:0] e;
    int n = 0;
    for (int i = 0; i < 3; i++) build_drop(0);
    add(SD,      pk(ST_MOV, 0, 0, e_h, 1'b0, 1'b0));
    add(SD | ST, pk(ST_MOV, 0, 0, e_h, 1'b0, 1'b0));
    add(SN,      pk(ST_MOV, 0, 0, e_h, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL full_column step %0d: got st=%0d col=%0d row=%0d h=%b ld=%b go=%b, want st=%0d col=%0d row=%0d h=%b ld=%b go=%b",
                 n, obs[16:14], obs[13:12], obs[11:10], obs[9:2], obs[1], obs[0],
                 e[16:14], e[13:12], e[11:10], e[9:2], e[1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_pause();
    logic [16:0] e;
    int n = 0;
    add(SU, pk(ST_PAUSE, 0, 0, e_h, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) add(ST, pk(ST_PAUSE, 0, 0, e_h, 1'b0, 1'b0));
    add(SD,      pk(ST_PAUSE, 0, 0, e_h, 1'b0, 1'b0));
    add(SR,      pk(ST_PAUSE, 0, 0, e_h, 1'b0, 1'b0));
    add(SU,      pk(ST_MOV,   0, 0, e_h, 1'b0, 1'b0));
    add(SR,      pk(ST_MOV,   1, 0, e_h, 1'b0, 1'b0));
    add(SU | SD, pk(ST_PAUSE, 1, 0, e_h, 1'b0, 1'b0));
    add(SU,      pk(ST_MOV,   1, 0, e_h, 1'b0, 1'b0));
    add(SL,      pk(ST_MOV,   0, 0, e_h, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL pause step %0d: got st=%0d col=%0d row=%0d h=%b ld=%b go=%b, want st=%0d col=%0d row=%0d h=%b ld=%b go=%b",
                 n, obs[16:14], obs[13:12], obs[11:10], obs[9:2], obs[1], obs[0],
                 e[16:14], e[13:12], e[11:10], e[9:2], e[1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_game_over();
    logic [16:0] e;
    int n = 0;
    for (int c = 1; c < 4; c++)
      while (e_h[2*c +: 2] != 2'd3) build_drop(c);
    add(ST,      pk(ST_OVER, 0, 0, e_h, 1'b0, 1'b1));
    add(SD,      pk(ST_OVER, 0, 0, e_h, 1'b0, 1'b1));
    add(SU,      pk(ST_OVER, 0, 0, e_h, 1'b0, 1'b1));
    add(SR | ST, pk(ST_OVER, 0, 0, e_h, 1'b0, 1'b1));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL game_over step %0d: got st=%0d col=%0d row=%0d h=%b ld=%b go=%b, want st=%0d col=%0d row=%0d h=%b ld=%b go=%b",
                 n, obs[16:14], obs[13:12], obs[11:10], obs[9:2], obs[1], obs[0],
                 e[16:14], e[13:12], e[11:10], e[9:2], e[1], e[0]);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_flight();
    logic [16:0] e;
    int n = 0;
    // Reset out of OVER, then again mid-FALLING.
    build_reset();
    build_init();
    add(SR, pk(ST_MOV,  1, 0, e_h, 1'b0, 1'b0));
    add(SD, pk(ST_FALL, 1, 0, e_h, 1'b0, 1'b0));
    add(ST, pk(ST_FALL, 1, 1, e_h, 1'b0, 1'b0));
    build_reset();
    // Reset during the LAND cycle: landed pulse and height are lost.
    build_init();
    add(SD, pk(ST_FALL, 0, 0, e_h, 1'b0, 1'b0));
    add(ST, pk(ST_FALL, 0, 1, e_h, 1'b0, 1'b0));
    add(ST, pk(ST_FALL, 0, 2, e_h, 1'b0, 1'b0));
    add(ST, pk(ST_LAND, 0, 2, 8'h01, 1'b1, 1'b0));
    build_reset();
    add(SN, pk(ST_INIT, 0, 0, 8'h00, 1'b0, 1'b0));
    while (stim_q.size() > 0) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset_mid_flight step %0d: got st=%0d col=%0d row=%0d h=%b ld=%b go=%b, want st=%0d col=%0d row=%0d h=%b ld=%b go=%b",
                 n, obs[16:14], obs[13:12], obs[11:10], obs[9:2], obs[1], obs[0],
                 e[16:14], e[13:12], e[11:10], e[9:2], e[1], e[0]);
      end
      n++;
    end
  endtask

  initial begin
    e_h = 8'd0;
    test_reset();
    test_init();
    test_moving();
    test_drop();
    test_full_column();
    test_pause();
    test_game_over();
    test_reset_mid_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_block_drop_ctrl
`default_nettype wire
